multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//   Main FSM of the multicycle RV32I core. Decodes the latched opcode, drives
//   ALUOp into the ALU controller, and steps through fetch/decode/execute/
//   memory/writeback. Waits on a ready/valid handshake to the shared memory.
//   Counts retired instructions.
// PARAMETERS
//   CNT_W   32  width of retired-instruction counter oInstret
// PORTS
//   iCLK        in   1   clock; all state changes on rising edge
//   iRST_N      in   1   asynchronous reset, active-low
//   iOpcode     in   7   instr[6:0] from IR; valid from DECODE onward
//   iZero       in   1   ALU zero flag (BEQ compare)
//   iMemReady   in   1   memory completed the current read/write this cycle
//   oALUOp      out  2   00=OP_ADD 01=OP_SUB 10=OP_ANY (funct3/funct7 decode)
//   oALUSrcA    out  2   00=PC 01=rs1 10=oldPC
//   oALUSrcB    out  2   00=rs2 01=const 4 10=imm
//   oIorD       out  1   memory address: 0=PC, 1=ALUOut
//   oMemRead    out  1   memory read request, held until iMemReady
//   oMemWrite   out  1   memory write request, held until iMemReady
//   oIRWrite    out  1   latch instruction and oldPC
//   oRegWrite   out  1   register-file write enable
//   oWBSel      out  2   00=ALUOut 01=MDR 10=PC+4
//   oPCWrite    out  1   unconditional PC load
//   oPCWriteCond out 1   PC load if iZero
//   oPCSource   out  1   0=ALU result, 1=ALUOut
//   oIllegal    out  1   pulse: unsupported opcode decoded
//   oInstret    out  CNT_W  retired-instruction count
// BEHAVIOUR
//   Reset (async, iRST_N=0): state=FETCH. oInstret=0.
//     All enables, requests and oIllegal are 0. Mux selects are 0.
//   Outputs are a pure function of state, except FETCH's oIRWrite/oPCWrite.
//   Supported opcodes: R=0110011, I-ALU=0010011, LW=0000011, SW=0100011,
//     BEQ=1100011, JAL=1101111, LUI=0110111.
//   States and transitions:
//   FETCH: oMemRead=1, IorD=0, SrcA=PC, SrcB=4, ALUOp=ADD.
//     On iMemReady: oIRWrite=1 and oPCWrite=1 (PCSource=0), go DECODE.
//     Otherwise stay in FETCH.
//   DECODE: SrcA=oldPC, SrcB=imm, ALUOp=ADD (branch target into ALUOut).
//     LW/SW -> MEMADR; R -> EXEC_R; I-ALU -> EXEC_I; BEQ -> BRANCH;
//     JAL -> JAL; LUI -> LUI; other -> FETCH with oIllegal=1 for 1 cycle.
//   MEMADR: SrcA=rs1, SrcB=imm, ADD. LW -> MEMRD; SW -> MEMWR.
//   MEMRD: oMemRead=1, IorD=1. Stay until iMemReady, then go MEMWB.
//   MEMWB: RegWrite=1, WBSel=MDR -> FETCH (retire).
//   MEMWR: oMemWrite=1, IorD=1. Stay until iMemReady, then FETCH (retire).
//   EXEC_R: SrcA=rs1, SrcB=rs2, ALUOp=ANY -> ALUWB.
//   EXEC_I: SrcA=rs1, SrcB=imm, ALUOp=ANY -> ALUWB.
//   ALUWB: RegWrite=1, WBSel=ALUOut -> FETCH (retire).
//   BRANCH: SrcA=rs1, SrcB=rs2, ALUOp=SUB, PCWriteCond=1, PCSource=1
//     -> FETCH (retire, taken or not).
//   JAL: RegWrite=1, WBSel=PC+4, PCWrite=1, PCSource=1 -> FETCH (retire).
//   LUI: SrcA=PC (forced to 0 by datapath when LUI), SrcB=imm, ADD -> ALUWB.
//   Retire: oInstret += 1 on the edge leaving a retiring state.
//     Wraps from all-ones to 0. Illegal opcodes do not retire.
//   Handshake: oMemRead/oMemWrite are never both 1. A request stays asserted,
//     with a stable address select, until iMemReady. iMemReady is ignored in
//     states that make no request.
//   Reset mid-operation: aborts immediately to FETCH. No write enable may
//     glitch high while iRST_N=0.
//   CPI without stalls: LW 5, SW 4, R/I/LUI 4, BEQ 3, JAL 3.
// TESTING
//   1. Reset, then R-type with iMemReady=1 every cycle: states FETCH,DECODE,
//      EXEC_R,ALUWB; oALUOp=10 in EXEC_R; RegWrite=1 only in ALUWB;
//      oInstret=1 after 4 cycles.
//   2. LW with iMemReady held 0 for 3 cycles in MEMRD: oMemRead and IorD=1
//      stay stable for 4 cycles; MEMWB follows; total 8 cycles; oInstret +1.
//   3. BEQ with iZero=1, then BEQ with iZero=0: oALUOp=01 and PCWriteCond=1
//      in BRANCH both times; each takes 3 cycles; oInstret +2.
//   4. Opcode 1111111: oIllegal pulses 1 cycle in DECODE, next state FETCH,
//      oInstret unchanged.
//   5. Drive iRST_N low in MEMWR with oMemWrite=1: oMemWrite drops
//      asynchronously; state=FETCH and oInstret=0 after release.
//   6. Preload counter near wrap (CNT_W=4), retire 2 JALs: count goes 15 -> 0
//      -> 1. Each JAL asserts RegWrite with WBSel=10.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback from the latched opcode,
// handshakes with the shared memory, and counts retired instructions.
//
// Ports:
//   iCLK, iRST_N   clock, asynchronous active-low reset
//   iOpcode        instr[6:0] from the IR (valid from DECODE onward)
//   iZero          ALU zero flag (consumed by the datapath PC-write gate)
//   iMemReady      memory finished the current read/write this cycle
//   oALUOp         00=ADD 01=SUB 10=funct decode
//   oALUSrcA       00=PC 01=rs1 10=oldPC
//   oALUSrcB       00=rs2 01=const 4 10=imm
//   oIorD          memory address select: 0=PC 1=ALUOut
//   oMemRead/oMemWrite  memory requests, held until iMemReady
//   oIRWrite       latch instruction and oldPC
//   oRegWrite      register-file write enable
//   oWBSel         00=ALUOut 01=MDR 10=PC+4
//   oPCWrite       unconditional PC load
//   oPCWriteCond   PC load when iZero
//   oPCSource      0=ALU result 1=ALUOut
//   oIllegal       one-cycle pulse on an unsupported opcode
//   oInstret       retired-instruction count (wraps)
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [6:0]       iOpcode,
  input  logic             iZero,
  input  logic             iMemReady,
  output logic [1:0]       oALUOp,
  output logic [1:0]       oALUSrcA,
  output logic [1:0]       oALUSrcB,
  output logic             oIorD,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oIRWrite,
  output logic             oRegWrite,
  output logic [1:0]       oWBSel,
  output logic             oPCWrite,
  output logic             oPCWriteCond,
  output logic             oPCSource,
  output logic             oIllegal,
  output logic [CNT_W-1:0] oInstret
);

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_ANY = 2'b10;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_RS1   = 2'b01;
  localparam logic [1:0] SA_OLDPC = 2'b10;

  localparam logic [1:0] SB_RS2   = 2'b00;
  localparam logic [1:0] SB_FOUR  = 2'b01;
  localparam logic [1:0] SB_IMM   = 2'b10;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MDR   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI
  } state_t;

  state_t state, state_nxt;
  logic   retire_c;

  // Zero flag is only used by the datapath's conditional PC write.
  logic unused_zero;
  assign unused_zero = iZero;

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= FETCH;
    else         state <= state_nxt;
  end

  // Retired-instruction counter, bumped on the edge leaving a retiring state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)       oInstret <= '0;
    else if (retire_c) oInstret <= oInstret + CNT_W'(1);
  end

  // Next state and control outputs. Everything is held at its idle value while
  // reset is asserted so no enable or request can pulse during reset, even if
  // iMemReady is high in FETCH.
  always_comb begin
    state_nxt    = state;
    retire_c     = 1'b0;
    oALUOp       = ALU_ADD;
    oALUSrcA     = SA_PC;
    oALUSrcB     = SB_RS2;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oIRWrite     = 1'b0;
    oRegWrite    = 1'b0;
    oWBSel       = WB_ALU;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oPCSource    = 1'b0;
    oIllegal     = 1'b0;

    if (iRST_N) begin
      case (state)
        FETCH: begin
          oMemRead = 1'b1;
          oALUSrcA = SA_PC;
          oALUSrcB = SB_FOUR;
          oALUOp   = ALU_ADD;
          if (iMemReady) begin
            oIRWrite  = 1'b1;
            oPCWrite  = 1'b1;
            state_nxt = DECODE;
          end
        end
        DECODE: begin
          // Precompute the branch/jump target into ALUOut.
          oALUSrcA = SA_OLDPC;
          oALUSrcB = SB_IMM;
          oALUOp   = ALU_ADD;
          case (iOpcode)
            OPC_LW, OPC_SW: state_nxt = MEMADR;
            OPC_R:          state_nxt = EXEC_R;
            OPC_I:          state_nxt = EXEC_I;
            OPC_BEQ:        state_nxt = BRANCH;
            OPC_JAL:        state_nxt = JAL;
            OPC_LUI:        state_nxt = LUI;
            default: begin
              oIllegal  = 1'b1;
              state_nxt = FETCH;
            end
          endcase
        end
        MEMADR: begin
          oALUSrcA  = SA_RS1;
          oALUSrcB  = SB_IMM;
          oALUOp    = ALU_ADD;
          state_nxt = (iOpcode == OPC_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          oMemRead = 1'b1;
          oIorD    = 1'b1;
          if (iMemReady) state_nxt = MEMWB;
        end
        MEMWB: begin
          oRegWrite = 1'b1;
          oWBSel    = WB_MDR;
          retire_c  = 1'b1;
          state_nxt = FETCH;
        end
        MEMWR: begin
          oMemWrite = 1'b1;
          oIorD     = 1'b1;
          if (iMemReady) begin
            retire_c  = 1'b1;
            state_nxt = FETCH;
          end
        end
        EXEC_R: begin
          oALUSrcA  = SA_RS1;
          oALUSrcB  = SB_RS2;
          oALUOp    = ALU_ANY;
          state_nxt = ALUWB;
        end
        EXEC_I: begin
          oALUSrcA  = SA_RS1;
          oALUSrcB  = SB_IMM;
          oALUOp    = ALU_ANY;
          state_nxt = ALUWB;
        end
        ALUWB: begin
          oRegWrite = 1'b1;
          oWBSel    = WB_ALU;
          retire_c  = 1'b1;
          state_nxt = FETCH;
        end
        BRANCH: begin
          oALUSrcA     = SA_RS1;
          oALUSrcB     = SB_RS2;
          oALUOp       = ALU_SUB;
          oPCWriteCond = 1'b1;
          oPCSource    = 1'b1;
          retire_c     = 1'b1;
          state_nxt    = FETCH;
        end
        JAL: begin
          oRegWrite = 1'b1;
          oWBSel    = WB_PC4;
          oPCWrite  = 1'b1;
          oPCSource = 1'b1;
          retire_c  = 1'b1;
          state_nxt = FETCH;
        end
        LUI: begin
          // Datapath forces the PC operand to zero for LUI.
          oALUSrcA  = SA_PC;
          oALUSrcB  = SB_IMM;
          oALUOp    = ALU_ADD;
          state_nxt = ALUWB;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule
